// File: rtl/load_word_reader.sv
// ============================================================================
// Module   : load_word_reader
// Brief    : Multi-cycle byte/halfword/word load unit over a byte-wide memory
// Revision : 1.0
// ============================================================================
`default_nettype none

module load_word_reader #(
    parameter int LAT = 1
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Req,
    input  logic [31:0] Addr,
    input  logic [1:0]  Size,
    input  logic        Sext,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic [31:0] Dout,
    output logic        Mem_RE,
    output logic [31:0] Mem_Addr,
    input  logic [7:0]  Mem_Data
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    localparam logic [1:0] c_wait_last = 2'((LAT > 1) ? (LAT - 2) : 0);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_size;
    logic        r_sext;
    logic [1:0]  r_k;
    logic [1:0]  r_last;
    logic [1:0]  r_wcnt;
    logic        r_err;
    logic [31:0] r_buf;
    logic [31:0] r_dout;
    logic [31:0] r_mem_addr;
    logic        w_illegal;
    logic [31:0] w_buf_next;
    logic [31:0] w_result;

    assign w_illegal = (Size == 2'b11)
                     | ((Size == 2'b01) & Addr[0])
                     | ((Size == 2'b10) & (|Addr[1:0]));

    // Result is formed from the buffer including the byte captured this cycle
    always_comb begin
        w_buf_next = r_buf;
        w_buf_next[{r_k, 3'b000} +: 8] = Mem_Data;
        case (r_size)
            2'b00:   w_result = {{24{r_sext & w_buf_next[7]}},  w_buf_next[7:0]};
            2'b01:   w_result = {{16{r_sext & w_buf_next[15]}}, w_buf_next[15:0]};
            default: w_result = w_buf_next;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (Req) w_next = w_illegal ? S_FIN : S_ISSUE;
            S_ISSUE:   w_next = (LAT > 1) ? S_WAIT : S_CAPTURE;
            S_WAIT:    if (r_wcnt == c_wait_last) w_next = S_CAPTURE;
            S_CAPTURE: w_next = (r_k == r_last) ? S_FIN : S_ISSUE;
            S_FIN:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state    <= S_IDLE;
            r_size     <= 2'b00;
            r_sext     <= 1'b0;
            r_k        <= 2'd0;
            r_last     <= 2'd0;
            r_wcnt     <= 2'd0;
            r_err      <= 1'b0;
            r_buf      <= 32'd0;
            r_dout     <= 32'd0;
            r_mem_addr <= 32'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (Req) begin
                        r_size <= Size;
                        r_sext <= Sext;
                        r_k    <= 2'd0;
                        r_last <= (Size == 2'b00) ? 2'd0 : ((Size == 2'b01) ? 2'd1 : 2'd3);
                        r_err  <= w_illegal;
                        if (!w_illegal) r_mem_addr <= Addr;
                    end
                end
                S_ISSUE: r_wcnt <= 2'd0;
                S_WAIT:  r_wcnt <= r_wcnt + 2'd1;
                S_CAPTURE: begin
                    r_buf <= w_buf_next;
                    if (r_k == r_last) begin
                        r_dout <= w_result;
                    end else begin
                        r_k        <= r_k + 2'd1;
                        r_mem_addr <= r_mem_addr + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy     = (r_state != S_IDLE);
    assign Done     = (r_state == S_FIN);
    assign Err      = Done & r_err;
    assign Mem_RE   = (r_state == S_ISSUE);
    assign Mem_Addr = r_mem_addr;
    assign Dout     = r_dout;

endmodule

`default_nettype wire

// File: tb/tb_load_word_reader.sv
// ============================================================================
// Module   : tb_load_word_reader
// Brief    : Scoreboard bench for load_word_reader at LAT=1 and LAT=3
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_load_word_reader;

    typedef struct {
        logic        err;
        logic [31:0] dout;
        int          due;
    } exp_t;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int L = (gi == 0) ? 1 : 3;

        logic        Rst_n, Req, Sext, Busy, Done, Err, Mem_RE;
        logic [31:0] Addr, Dout, Mem_Addr;
        logic [1:0]  Size;
        logic [7:0]  Mem_Data;
        logic [7:0]  mem  [0:1023];
        logic [7:0]  pipe [0:2];
        exp_t        exp_q[$];
        logic [31:0] addr_q[$];
        logic [31:0] model_dout;
        int          re_cnt = 0;
        logic        fin = 1'b0;

        load_word_reader #(.LAT(L)) dut (
            .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Addr(Addr), .Size(Size),
            .Sext(Sext), .Busy(Busy), .Done(Done), .Err(Err), .Dout(Dout),
            .Mem_RE(Mem_RE), .Mem_Addr(Mem_Addr), .Mem_Data(Mem_Data)
        );

        // Synchronous memory: data read at the Mem_RE edge appears LAT cycles later
        always @(posedge Clk) begin
            pipe[0] <= Mem_RE ? mem[Mem_Addr[9:0]] : 8'($urandom);
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign Mem_Data = pipe[L-1];

        task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL L=%0d %s: got %h expected %h", L, name, act, exp);
            end
        endtask

        task automatic fail(input string name, input logic [31:0] act);
            total++;
            bad++;
            $display("FAIL L=%0d %s: got %h expected none", L, name, act);
        endtask

        task automatic check_zero_outputs(input string tag);
            chk({tag, "_busy"},  32'(Busy),   32'd0);
            chk({tag, "_done"},  32'(Done),   32'd0);
            chk({tag, "_err"},   32'(Err),    32'd0);
            chk({tag, "_re"},    32'(Mem_RE), 32'd0);
            chk({tag, "_maddr"}, Mem_Addr,    32'd0);
            chk({tag, "_dout"},  Dout,        32'd0);
        endtask

        task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sx);
            int          n, t;
            logic        legal;
            logic [31:0] v, ai, mask;
            exp_t        e;
            @(negedge Clk);
            t = 0;
            while (Busy && t < 100) begin
                @(negedge Clk);
                t++;
            end
            if (Busy) fail("idle_timeout", 32'(Busy));
            n     = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
            legal = (sz != 2'd3) && ((a % n) == 0);
            v     = 32'd0;
            if (legal) begin
                for (int i = 0; i < n; i++) begin
                    ai = a + 32'(i);
                    v  = v | (32'(mem[ai[9:0]]) << (8 * i));
                    addr_q.push_back(ai);
                end
                if (n < 4) begin
                    mask = (32'd1 << (8 * n)) - 32'd1;
                    if (sx && v[8*n-1]) v = v | ~mask;
                end
                model_dout = v;
            end
            Req = 1'b1; Addr = a; Size = sz; Sext = sx;
            @(posedge Clk);
            #1;
            Req = 1'b0; Addr = $urandom; Size = 2'($urandom); Sext = 1'($urandom);
            e.err  = !legal;
            e.dout = model_dout;
            e.due  = cyc + (legal ? n * (L + 1) : 0);
            exp_q.push_back(e);
        endtask

        initial begin : monitor
            exp_t e;
            forever begin
                @(negedge Clk);
                if (Mem_RE) begin
                    re_cnt++;
                    if (addr_q.size() == 0) fail("unexpected_mem_re", Mem_Addr);
                    else chk("mem_addr", Mem_Addr, addr_q.pop_front());
                end
                if (Done) begin
                    chk("no_re_with_done", 32'(Mem_RE), 32'd0);
                    if (exp_q.size() == 0) fail("unexpected_done", Dout);
                    else begin
                        e = exp_q.pop_front();
                        chk("err",        32'(Err), 32'(e.err));
                        chk("dout",       Dout,     e.dout);
                        chk("done_cycle", 32'(cyc), 32'(e.due));
                    end
                end
            end
        end

        initial begin : stimulus
            int          t, rc;
            logic [31:0] a;
            logic [1:0]  sz;
            Rst_n = 1'b0; Req = 1'b0; Addr = 32'd0; Size = 2'd0; Sext = 1'b0;
            model_dout = 32'd0;
            for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
            mem[10'h100] = 8'h11; mem[10'h101] = 8'h22; mem[10'h102] = 8'h33; mem[10'h103] = 8'h44;
            mem[10'h007] = 8'h80;
            mem[10'h022] = 8'hFE; mem[10'h023] = 8'hFF;
            repeat (3) @(negedge Clk);
            check_zero_outputs("reset");
            Rst_n = 1'b1;

            do_load(32'h100, 2'b10, 1'b0);
            do_load(32'h007, 2'b00, 1'b1);
            do_load(32'h007, 2'b00, 1'b0);
            do_load(32'h022, 2'b01, 1'b1);
            do_load(32'h102, 2'b10, 1'b0);
            do_load(32'h040, 2'b11, 1'b1);

            // Requests while busy must be ignored
            do_load(32'h300, 2'b10, 1'b1);
            repeat (8) begin
                @(negedge Clk);
                Req  = Busy ? 1'($urandom) : 1'b0;
                Addr = $urandom;
                Size = 2'($urandom);
            end
            Req = 1'b0;

            repeat (30) begin
                sz = 2'($urandom);
                a  = 32'($urandom_range(0, 4095));
                if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
                do_load(a, sz, 1'($urandom));
            end

            // Reset in the middle of a word load
            do_load(32'h200, 2'b10, 1'b0);
            rc = re_cnt;
            t  = 0;
            while (re_cnt < rc + 2 && t < 100) begin
                @(negedge Clk);
                t++;
            end
            if (re_cnt < rc + 2) fail("re_wait_timeout", 32'(re_cnt));
            #3;
            Rst_n = 1'b0;
            #1;
            check_zero_outputs("midload_reset");
            exp_q.delete();
            addr_q.delete();
            model_dout = 32'd0;
            @(negedge Clk);
            Rst_n = 1'b1;
            repeat (20) @(negedge Clk);
            do_load(32'h009, 2'b00, 1'b1);
            do_load(32'h104, 2'b01, 1'b0);

            t = 0;
            while ((exp_q.size() != 0 || addr_q.size() != 0) && t < 200) begin
                @(negedge Clk);
                t++;
            end
            if (exp_q.size() != 0 || addr_q.size() != 0) fail("drain_timeout", 32'(exp_q.size()));
            fin = 1'b1;
        end
    end

    initial begin : finisher
        int t;
        t = 0;
        while (!(g_inst[0].fin && g_inst[1].fin) && t < 20000) begin
            @(negedge Clk);
            t++;
        end
        if (!(g_inst[0].fin && g_inst[1].fin)) begin
            total++;
            bad++;
            $display("FAIL global_timeout: got unfinished expected finished");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
